hpi_slave_port: RTL

- Synthesizable responder for the CY7C67300 Host Port Interface: the target side of the HPI bus that the host-side HPI controller drives.
- Used as a loopback target in bench and on-board bring-up, and as an FPGA-to-FPGA HPI link.
- Contains the four HPI registers (DATA, MAILBOX, ADDRESS, STATUS), a word-addressed internal RAM and a two-way mailbox to local logic.
- The HPI pins are sampled on clk (32 MHz, at least 4x the strobe rate).

---
 rtl/hpi_pkg.sv | 33 +++
 rtl/hpi_slave_port_if.sv | 13 +
 rtl/hpi_strobe_sync.sv | 55 +++++
 rtl/hpi_slave_port.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// Shared HPI definitions: register select codes, transaction FSM states and STATUS word layout.
// Used by both the host-side controller and the hpi_slave_port responder.
package hpi_pkg;

  localparam int unsigned HPI_DW = 16;

  typedef enum logic [1:0] {
    HPI_REG_DATA    = 2'b00,
    HPI_REG_MAILBOX = 2'b01,
    HPI_REG_ADDRESS = 2'b10,
    HPI_REG_STATUS  = 2'b11
  } hpi_reg_e;

  typedef enum logic [1:0] {
    HPI_ST_IDLE  = 2'd0,
    HPI_ST_WRITE = 2'd1,
    HPI_ST_READ  = 2'd2
  } hpi_state_e;

  localparam int unsigned HPI_STS_MBX_OUT_FULL = 0;
  localparam int unsigned HPI_STS_MBX_IN_VALID = 1;
  localparam int unsigned HPI_STS_OVERRUN      = 2;
  localparam int unsigned HPI_STS_ERR          = 3;

  typedef struct packed {
    logic [11:0] rsvd;
    logic        err;
    logic        overrun;
    logic        mbx_in_valid;
    logic        mbx_out_full;
  } hpi_status_t;

endpackage

// File: rtl/hpi_slave_port_if.sv
// HPI control/strobe signals between host-side controller (master) and responder (slave).
// The 16-bit data bus is a plain inout on the responder so tristate resolution stays at port level.
interface hpi_slave_port_if;
  logic [1:0] hpi_address;
  logic       hpi_oen;
  logic       hpi_wen;
  logic       hpi_csn;
  logic       hpi_resetn;
  logic       hpi_irq;

  modport master (output hpi_address, hpi_oen, hpi_wen, hpi_csn, hpi_resetn, input hpi_irq);
  modport slave  (input hpi_address, hpi_oen, hpi_wen, hpi_csn, hpi_resetn, output hpi_irq);
endinterface

// File: rtl/hpi_strobe_sync.sv
// Synchronizes the asynchronous HPI strobes and soft reset into clk, then qualifies accesses.
// An access may only start after the strobes have been seen idle, so nothing restarts mid-strobe after a reset.
module hpi_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic csn,
  input  logic oen,
  input  logic wen,
  input  logic resetn,
  output logic wr_acc_c,
  output logic rd_acc_c,
  output logic wr_start_c,
  output logic rd_start_c,
  output logic illegal_c,
  output logic soft_rst_c
);

  logic [SYNC_STAGES-1:0] csn_q, oen_q, wen_q, rstn_q;
  logic csn_s, oen_s, wen_s, idle_c, armed;

  // Strobe chains reset to "active" so a strobe still low after reset never looks like a fresh edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_q  <= '0;
      oen_q  <= '0;
      wen_q  <= '0;
      rstn_q <= '1;
    end else begin
      csn_q  <= {csn_q[SYNC_STAGES-2:0], csn};
      oen_q  <= {oen_q[SYNC_STAGES-2:0], oen};
      wen_q  <= {wen_q[SYNC_STAGES-2:0], wen};
      rstn_q <= {rstn_q[SYNC_STAGES-2:0], resetn};
    end
  end

  assign csn_s      = csn_q[SYNC_STAGES-1];
  assign oen_s      = oen_q[SYNC_STAGES-1];
  assign wen_s      = wen_q[SYNC_STAGES-1];
  assign soft_rst_c = ~rstn_q[SYNC_STAGES-1];
  assign idle_c     = csn_s | (oen_s & wen_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) armed <= 1'b0;
    else       armed <= idle_c & ~soft_rst_c;
  end

  assign wr_acc_c   = ~csn_s & ~wen_s &  oen_s;
  assign rd_acc_c   = ~csn_s & ~oen_s &  wen_s;
  assign wr_start_c = armed & wr_acc_c;
  assign rd_start_c = armed & rd_acc_c;
  assign illegal_c  = armed & ~csn_s & ~oen_s & ~wen_s;

endmodule

// File: rtl/hpi_slave_port.sv
// CY7C67300 HPI target: DATA/MAILBOX/ADDRESS/STATUS registers, word RAM and two-way mailbox.
// Define HPI_SLAVE_AUTOINC_EN to post-increment the address by 2 on DATA accesses.
module hpi_slave_port
  import hpi_pkg::*;
#(
  parameter int unsigned MEM_AW      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  hpi_slave_port_if.slave   hpi,
  inout  wire  [HPI_DW-1:0] hpi_data,
  input  logic [HPI_DW-1:0] loc_mbx_wdata,
  input  logic              loc_mbx_wr,
  output logic              loc_mbx_full,
  output logic [HPI_DW-1:0] loc_mbx_rdata,
  output logic              loc_mbx_valid,
  input  logic              loc_mbx_ack
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

  hpi_state_e        state, state_nxt;
  hpi_reg_e          acc_reg;
  hpi_status_t       status_c;
  logic              wr_acc_c, rd_acc_c, wr_start_c, rd_start_c, illegal_c, soft_rst_c;
  logic              fsm_wr_start_c, fsm_rd_start_c, err_set_c, sample_c, wr_commit_c, rd_commit_c;
  logic [HPI_DW-1:0] addr_reg, addr_step_c, rd_latch, wr_data, mbx_out_data, ram_q_c;
  logic [MEM_AW-1:0] ram_idx;
  logic              reload, mbx_out_full, overrun, err;
  logic [HPI_DW-1:0] mem [MEM_DEPTH];

  hpi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .csn        (hpi.hpi_csn),
    .oen        (hpi.hpi_oen),
    .wen        (hpi.hpi_wen),
    .resetn     (hpi.hpi_resetn),
    .wr_acc_c   (wr_acc_c),
    .rd_acc_c   (rd_acc_c),
    .wr_start_c (wr_start_c),
    .rd_start_c (rd_start_c),
    .illegal_c  (illegal_c),
    .soft_rst_c (soft_rst_c)
  );

  // Read data is driven straight from the raw pins to meet host access time
  assign hpi_data = (~hpi.hpi_csn & ~hpi.hpi_oen & hpi.hpi_wen) ? rd_latch : 16'bz;

  assign hpi.hpi_irq   = mbx_out_full;
  assign loc_mbx_full  = mbx_out_full;
  assign ram_idx       = addr_reg[MEM_AW:1];
  assign ram_q_c       = mem[ram_idx];

`ifdef HPI_SLAVE_AUTOINC_EN
  assign addr_step_c = addr_reg + 16'd2;
`else
  assign addr_step_c = addr_reg;
`endif

  always_comb begin
    status_c              = '0;
    status_c.err          = err;
    status_c.overrun      = overrun;
    status_c.mbx_in_valid = loc_mbx_valid;
    status_c.mbx_out_full = mbx_out_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HPI_ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (soft_rst_c) begin
      state_nxt = HPI_ST_IDLE;
    end else begin
      case (state)
        HPI_ST_IDLE: begin
          if (wr_start_c)      state_nxt = HPI_ST_WRITE;
          else if (rd_start_c) state_nxt = HPI_ST_READ;
        end
        HPI_ST_WRITE: if (!wr_acc_c) state_nxt = HPI_ST_IDLE;
        HPI_ST_READ:  if (!rd_acc_c) state_nxt = HPI_ST_IDLE;
        default:      state_nxt = HPI_ST_IDLE;
      endcase
    end
  end

  // Write data is only captured while the raw strobe is still low, so the last word before release wins
  always_comb begin
    fsm_wr_start_c = 1'b0;
    fsm_rd_start_c = 1'b0;
    err_set_c      = 1'b0;
    sample_c       = 1'b0;
    wr_commit_c    = 1'b0;
    rd_commit_c    = 1'b0;
    if (!soft_rst_c) begin
      case (state)
        HPI_ST_IDLE: begin
          fsm_wr_start_c = wr_start_c;
          fsm_rd_start_c = rd_start_c;
          err_set_c      = illegal_c;
        end
        HPI_ST_WRITE: begin
          sample_c    = ~hpi.hpi_wen & ~hpi.hpi_csn;
          wr_commit_c = ~wr_acc_c;
        end
        HPI_ST_READ: rd_commit_c = ~rd_acc_c;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit_c && acc_reg == HPI_REG_DATA) mem[ram_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg      <= '0;
      rd_latch      <= '0;
      wr_data       <= '0;
      acc_reg       <= HPI_REG_DATA;
      reload        <= 1'b0;
      mbx_out_data  <= '0;
      mbx_out_full  <= 1'b0;
      loc_mbx_rdata <= '0;
      loc_mbx_valid <= 1'b0;
      overrun       <= 1'b0;
      err           <= 1'b0;
    end else if (soft_rst_c) begin
      addr_reg      <= '0;
      rd_latch      <= '0;
      wr_data       <= '0;
      acc_reg       <= HPI_REG_DATA;
      reload        <= 1'b0;
      mbx_out_full  <= 1'b0;
      loc_mbx_valid <= 1'b0;
      overrun       <= 1'b0;
      err           <= 1'b0;
    end else begin
      reload <= 1'b0;
      if (reload) rd_latch <= ram_q_c;
      if (fsm_wr_start_c || fsm_rd_start_c) acc_reg <= hpi_reg_e'(hpi.hpi_address);
      if (fsm_rd_start_c) begin
        case (hpi_reg_e'(hpi.hpi_address))
          HPI_REG_DATA:    rd_latch <= ram_q_c;
          HPI_REG_MAILBOX: rd_latch <= mbx_out_data;
          HPI_REG_ADDRESS: rd_latch <= addr_reg;
          HPI_REG_STATUS:  rd_latch <= status_c;
        endcase
      end
      if (sample_c) wr_data <= hpi_data;

      if (wr_commit_c && acc_reg == HPI_REG_ADDRESS) begin
        addr_reg <= wr_data;
        reload   <= 1'b1;
      end else if ((wr_commit_c || rd_commit_c) && acc_reg == HPI_REG_DATA) begin
        addr_reg <= addr_step_c;
        reload   <= 1'b1;
      end

      // Local write beats a concurrent host read of the outgoing mailbox
      if (loc_mbx_wr) begin
        mbx_out_data <= loc_mbx_wdata;
        mbx_out_full <= 1'b1;
      end else if (rd_commit_c && acc_reg == HPI_REG_MAILBOX) begin
        mbx_out_full <= 1'b0;
      end

      // Host write beats a concurrent local ack; an ack in the same cycle suppresses overrun
      if (wr_commit_c && acc_reg == HPI_REG_MAILBOX) begin
        loc_mbx_rdata <= wr_data;
        loc_mbx_valid <= 1'b1;
        if (loc_mbx_valid && !loc_mbx_ack) overrun <= 1'b1;
      end else if (loc_mbx_ack) begin
        loc_mbx_valid <= 1'b0;
      end

      if (wr_commit_c && acc_reg == HPI_REG_STATUS) begin
        overrun <= 1'b0;
        err     <= 1'b0;
      end else if (err_set_c) begin
        err <= 1'b1;
      end
    end
  end

endmodule
